// File: rtl/cac_wsum_dec_seq.sv
// Multi-cycle weighted-sum decoder for crosstalk-avoidance codewords.
// One wire group is accumulated per cycle; the result is held until the sink accepts it.
module cac_wsum_dec_seq #(
  parameter int NG   = 4,
  parameter int GW   = 3,
  parameter int BLEN = 8,
  parameter logic [NG*GW*BLEN-1:0] WTAB = 96'h0C0B0A09_08070605_04030201
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [NG*GW-1:0] codein,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [BLEN-1:0]  dataout,
  output logic             ovf,
  output logic             busy
);

  localparam int GRPW = (NG > 1) ? $clog2(NG) : 1;
  // Wide enough to hold GW full-scale weights without wrapping.
  localparam int PW   = BLEN + $clog2(GW + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACC  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [NG*GW-1:0] code_reg;
  logic [BLEN-1:0]  acc;
  logic             ovf_acc;
  logic [GRPW-1:0]  grp;

  logic [PW-1:0]    grp_part [NG];
  logic [PW-1:0]    part;
  logic [PW:0]      sum;
  logic             carry;
  logic             last;

  for (genvar gi = 0; gi < NG; gi++) begin : g_grp
    logic [PW-1:0] s;
    always_comb begin
      s = '0;
      for (int j = 0; j < GW; j++) begin
        if (code_reg[gi*GW+j])
          s = s + {{(PW-BLEN){1'b0}}, WTAB[(gi*GW+j)*BLEN +: BLEN]};
      end
    end
    assign grp_part[gi] = s;
  end

  always_comb begin
    part = '0;
    for (int g = 0; g < NG; g++) begin
      if (grp == GRPW'(g))
        part = grp_part[g];
    end
  end

  // Any bit at or above BLEN means the true sum no longer fits: carry out or oversized part.
  assign sum   = {1'b0, {(PW-BLEN){1'b0}}, acc} + {1'b0, part};
  assign carry = |sum[PW:BLEN];
  assign last  = (grp == GRPW'(NG-1));

  assign in_ready  = rst_n && (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      code_reg <= '0;
      acc      <= '0;
      ovf_acc  <= 1'b0;
      grp      <= '0;
      dataout  <= '0;
      ovf      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            code_reg <= codein;
            acc      <= '0;
            ovf_acc  <= 1'b0;
            grp      <= '0;
            state    <= ACC;
          end
        end
        ACC: begin
          acc     <= sum[BLEN-1:0];
          ovf_acc <= ovf_acc | carry;
          grp     <= grp + GRPW'(1);
          if (last) begin
            dataout <= sum[BLEN-1:0];
            ovf     <= ovf_acc | carry;
            state   <= DONE;
          end
        end
        DONE: begin
          if (out_ready)
            state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
